// File: rtl/vga_pkg.sv
// Shared timing defaults, widths and types for the 640x480@60 VGA timing generator.
package vga_pkg;

  localparam int DEF_H_VIS  = 640;
  localparam int DEF_H_FP   = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP   = 48;
  localparam int DEF_V_VIS  = 480;
  localparam int DEF_V_FP   = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP   = 33;

  localparam int DEF_H_TOT = DEF_H_VIS + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOT = DEF_V_VIS + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int DEF_PIX_W = 12;
  localparam int CNT_W     = 10;

  typedef logic [DEF_PIX_W-1:0] pix_t;
  typedef logic [CNT_W-1:0]     cnt_t;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic active;
    logic enable;
  } vga_ctrl_t;

  localparam int CTRL_W = $bits(vga_ctrl_t);

  localparam vga_ctrl_t CTRL_IDLE = '{hsync: 1'b1, vsync: 1'b1, active: 1'b0, enable: 1'b0};

  // Unsigned wrap-around makes "val in [start, start+len)" a single compare.
  function automatic logic in_span(cnt_t val, cnt_t start, cnt_t len);
    cnt_t rel;
    rel = val - start;
    return rel < len;
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register that re-aligns sync/blank/window flags with frame-buffer read data.
module vga_delay_line
  import vga_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CTRL_W-1:0] din,
  output logic [CTRL_W-1:0] dout
);

  vga_ctrl_t stage [DEPTH];

  // Reset fills the line with idle levels so no stray sync pulse or pixel leaves after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= CTRL_IDLE;
      end
    end else begin
      stage[0] <= vga_ctrl_t'(din);
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing, frame-buffer window strobe and pixel/sync output alignment.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_VIS  = DEF_H_VIS,
  parameter int H_FP   = DEF_H_FP,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP   = DEF_H_BP,
  parameter int V_VIS  = DEF_V_VIS,
  parameter int V_FP   = DEF_V_FP,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP   = DEF_V_BP,
  parameter int WIN_X  = 0,
  parameter int WIN_Y  = 0,
  parameter int WIN_W  = 160,
  parameter int WIN_H  = 120,
  parameter int RD_LAT = 1,
  parameter int PIX_W  = DEF_PIX_W
) (
  input  logic             clk25,
  input  logic             rst,
  output logic             enable,
  output logic             vsync,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             frame_start,
  input  logic [PIX_W-1:0] pixel_in,
  output logic             vga_hsync,
  output logic             vga_vsync,
  output logic [PIX_W-1:0] vga_rgb
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  localparam cnt_t H_LAST   = cnt_t'(H_TOT - 1);
  localparam cnt_t V_LAST   = cnt_t'(V_TOT - 1);
  localparam cnt_t HS_START = cnt_t'(H_VIS + H_FP);
  localparam cnt_t HS_LEN   = cnt_t'(H_SYNC);
  localparam cnt_t VS_START = cnt_t'(V_VIS + V_FP);
  localparam cnt_t VS_LEN   = cnt_t'(V_SYNC);
  localparam cnt_t H_VIS_C  = cnt_t'(H_VIS);
  localparam cnt_t V_VIS_C  = cnt_t'(V_VIS);
  localparam cnt_t WX_C     = cnt_t'(WIN_X);
  localparam cnt_t WY_C     = cnt_t'(WIN_Y);
  localparam cnt_t WW_C     = cnt_t'(WIN_W);
  localparam cnt_t WH_C     = cnt_t'(WIN_H);

  if ((WIN_X + WIN_W > H_VIS) || (WIN_Y + WIN_H > V_VIS)) begin : g_window_check
    $error("vga_timing_gen: frame-buffer window extends past the visible area");
  end
  if ((RD_LAT < 1) || (RD_LAT > 4)) begin : g_latency_check
    $error("vga_timing_gen: RD_LAT must be in 1..4");
  end
  if ((H_TOT > (1 << CNT_W)) || (V_TOT > (1 << CNT_W))) begin : g_counter_check
    $error("vga_timing_gen: line or frame total does not fit the raster counters");
  end

  cnt_t      h_cnt;
  cnt_t      v_cnt;
  logic      h_wrap;
  vga_ctrl_t ctrl_next;
  vga_ctrl_t ctrl_s0;
  vga_ctrl_t ctrl_dly;
  logic      frame_next;

  assign h_wrap = (h_cnt == H_LAST);

  // v_cnt only moves on a line wrap, so the last line of the frame wraps both counters together.
  always_ff @(posedge clk25 or negedge rst) begin
    if (!rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_wrap) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + cnt_t'(1);
    end else begin
      h_cnt <= h_cnt + cnt_t'(1);
    end
  end

  always_comb begin
    ctrl_next        = CTRL_IDLE;
    ctrl_next.hsync  = !in_span(h_cnt, HS_START, HS_LEN);
    ctrl_next.vsync  = !in_span(v_cnt, VS_START, VS_LEN);
    ctrl_next.active = (h_cnt < H_VIS_C) && (v_cnt < V_VIS_C);
    ctrl_next.enable = in_span(h_cnt, WX_C, WW_C) && in_span(v_cnt, WY_C, WH_C);
  end

  assign frame_next = (h_cnt == '0) && (v_cnt == '0);

  always_ff @(posedge clk25 or negedge rst) begin
    if (!rst) begin
      hcount      <= '0;
      vcount      <= '0;
      frame_start <= 1'b0;
      ctrl_s0     <= CTRL_IDLE;
    end else begin
      hcount      <= h_cnt;
      vcount      <= v_cnt;
      frame_start <= frame_next;
      ctrl_s0     <= ctrl_next;
    end
  end

  assign enable = ctrl_s0.enable;
  assign vsync  = ctrl_s0.vsync;

  vga_delay_line #(
    .DEPTH (RD_LAT)
  ) u_delay (
    .clk   (clk25),
    .rst_n (rst),
    .din   (ctrl_s0),
    .dout  (ctrl_dly)
  );

  // Gating with active as well as enable keeps the DAC dark in blanking even for a misplaced window.
  always_ff @(posedge clk25 or negedge rst) begin
    if (!rst) begin
      vga_rgb   <= '0;
      vga_hsync <= 1'b1;
      vga_vsync <= 1'b1;
    end else begin
      vga_rgb   <= (ctrl_dly.enable && ctrl_dly.active) ? pixel_in : '0;
      vga_hsync <= ctrl_dly.hsync;
      vga_vsync <= ctrl_dly.vsync;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: one default-timing instance plus two scaled-down rasters
// (origin and offset window) checked cycle by cycle against a closed-form raster model.
module tb_vga_timing_gen;

  localparam int NI = 3;

  typedef struct {
    int h_vis; int h_fp; int h_sync; int h_bp;
    int v_vis; int v_fp; int v_sync; int v_bp;
    int wx; int wy; int ww; int wh;
  } cfg_t;

  typedef struct packed {
    logic [9:0] hcount;
    logic [9:0] vcount;
    logic       hsync;
    logic       vsync;
    logic       enable;
    logic       active;
    logic       fs;
  } s0_t;

  typedef struct packed {
    logic        hsync;
    logic        vsync;
    logic [11:0] rgb;
  } pin_t;

  typedef struct {
    int   inst;
    int   h;
    int   v;
    logic en;
    logic vs;
    logic hs;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [11:0] pix_i  [NI];
  logic        en_o   [NI];
  logic        vs_o   [NI];
  logic        fs_o   [NI];
  logic        vh_o   [NI];
  logic        vv_o   [NI];
  logic [9:0]  hc_o   [NI];
  logic [9:0]  vc_o   [NI];
  logic [11:0] rgb_o  [NI];

  int   checks;
  int   failures;
  int   n;
  pin_t exp_q [NI][$];
  vec_t vecs [$];
  int   last_fs [NI];
  int   en_cnt  [NI];
  int   vs_cnt  [NI];
  int   hs_run  [NI];

  vga_timing_gen u_full (
    .clk25(clk), .rst(rst), .enable(en_o[0]), .vsync(vs_o[0]), .hcount(hc_o[0]),
    .vcount(vc_o[0]), .frame_start(fs_o[0]), .pixel_in(pix_i[0]), .vga_hsync(vh_o[0]),
    .vga_vsync(vv_o[0]), .vga_rgb(rgb_o[0])
  );

  vga_timing_gen #(
    .H_VIS(40), .H_FP(4), .H_SYNC(8), .H_BP(8), .V_VIS(30), .V_FP(2), .V_SYNC(2), .V_BP(4),
    .WIN_X(0), .WIN_Y(0), .WIN_W(10), .WIN_H(8)
  ) u_small (
    .clk25(clk), .rst(rst), .enable(en_o[1]), .vsync(vs_o[1]), .hcount(hc_o[1]),
    .vcount(vc_o[1]), .frame_start(fs_o[1]), .pixel_in(pix_i[1]), .vga_hsync(vh_o[1]),
    .vga_vsync(vv_o[1]), .vga_rgb(rgb_o[1])
  );

  vga_timing_gen #(
    .H_VIS(40), .H_FP(4), .H_SYNC(8), .H_BP(8), .V_VIS(30), .V_FP(2), .V_SYNC(2), .V_BP(4),
    .WIN_X(12), .WIN_Y(9), .WIN_W(10), .WIN_H(8)
  ) u_offset (
    .clk25(clk), .rst(rst), .enable(en_o[2]), .vsync(vs_o[2]), .hcount(hc_o[2]),
    .vcount(vc_o[2]), .frame_start(fs_o[2]), .pixel_in(pix_i[2]), .vga_hsync(vh_o[2]),
    .vga_vsync(vv_o[2]), .vga_rgb(rgb_o[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic cfg_t get_cfg(int i);
    cfg_t c;
    if (i == 0)      c = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 160, 120};
    else if (i == 1) c = '{40, 4, 8, 8, 30, 2, 2, 4, 0, 0, 10, 8};
    else             c = '{40, 4, 8, 8, 30, 2, 2, 4, 12, 9, 10, 8};
    return c;
  endfunction

  // Stage-0 outputs after clock edge n since reset release (edge n shows raster position n-1).
  function automatic s0_t model_s0(int i, int edge_n);
    cfg_t c;
    s0_t  s;
    int   ht, vt, k, h, v;
    c = get_cfg(i);
    ht = c.h_vis + c.h_fp + c.h_sync + c.h_bp;
    vt = c.v_vis + c.v_fp + c.v_sync + c.v_bp;
    s = '{hcount: 10'd0, vcount: 10'd0, hsync: 1'b1, vsync: 1'b1, enable: 1'b0, active: 1'b0, fs: 1'b0};
    if (edge_n > 0) begin
      k = edge_n - 1;
      h = k % ht;
      v = (k / ht) % vt;
      s.hcount = 10'(h);
      s.vcount = 10'(v);
      s.hsync  = !((h >= c.h_vis + c.h_fp) && (h < c.h_vis + c.h_fp + c.h_sync));
      s.vsync  = !((v >= c.v_vis + c.v_fp) && (v < c.v_vis + c.v_fp + c.v_sync));
      s.enable = (h >= c.wx) && (h < c.wx + c.ww) && (v >= c.wy) && (v < c.wy + c.wh);
      s.active = (h < c.h_vis) && (v < c.v_vis);
      s.fs     = (h == 0) && (v == 0);
    end
    return s;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input int inst, input int h, input int v, input logic en,
                         input logic vs, input logic hs);
    vec_t e;
    e.inst = inst; e.h = h; e.v = v; e.en = en; e.vs = vs; e.hs = hs;
    vecs.push_back(e);
  endtask

  // After edge m, drive the read data for the window flag of edge m-1 and queue the pins for edge m+1.
  task automatic push_for(input int i, input int m);
    s0_t  s;
    pin_t p;
    s = model_s0(i, m - 1);
    pix_i[i] = {s.vcount[5:0], s.hcount[5:0]};
    p.hsync = s.hsync;
    p.vsync = s.vsync;
    p.rgb   = (s.enable && s.active) ? {s.vcount[5:0], s.hcount[5:0]} : 12'd0;
    exp_q[i].push_back(p);
  endtask

  task automatic apply_stimulus();
    for (int i = 0; i < NI; i++) push_for(i, n);
  endtask

  task automatic check_output();
    for (int i = 0; i < NI; i++) begin
      cfg_t c;
      s0_t  s;
      pin_t p;
      int   ht, vt;
      c  = get_cfg(i);
      ht = c.h_vis + c.h_fp + c.h_sync + c.h_bp;
      vt = c.v_vis + c.v_fp + c.v_sync + c.v_bp;
      s  = model_s0(i, n);
      if (exp_q[i].size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL scoreboard inst%0d cycle%0d: got 0 queued entries, expected 1", i, n);
        p = '{hsync: 1'b1, vsync: 1'b1, rgb: 12'd0};
      end else begin
        p = exp_q[i].pop_front();
      end
      check($sformatf("outputs inst%0d cycle%0d", i, n),
            64'({hc_o[i], vc_o[i], vs_o[i], en_o[i], fs_o[i], vh_o[i], vv_o[i], rgb_o[i]}),
            64'({s.hcount, s.vcount, s.vsync, s.enable, s.fs, p.hsync, p.vsync, p.rgb}));

      foreach (vecs[k]) begin
        int ne;
        if (vecs[k].inst == i) begin
          ne = vecs[k].v * ht + vecs[k].h + 1;
          if (n == ne)
            check($sformatf("vec inst%0d h%0d v%0d", i, vecs[k].h, vecs[k].v),
                  64'({hc_o[i], vc_o[i], en_o[i], vs_o[i]}),
                  64'({10'(vecs[k].h), 10'(vecs[k].v), vecs[k].en, vecs[k].vs}));
          if (n == ne + 2)
            check($sformatf("vec_hsync inst%0d h%0d v%0d", i, vecs[k].h, vecs[k].v),
                  64'(vh_o[i]), 64'(vecs[k].hs));
        end
      end

      if (fs_o[i]) begin
        if (last_fs[i] > 0) begin
          check($sformatf("frame_period inst%0d", i), 64'(n - last_fs[i]), 64'(ht * vt));
          check($sformatf("enable_count inst%0d", i), 64'(en_cnt[i]), 64'(c.ww * c.wh));
          check($sformatf("vsync_low inst%0d", i), 64'(vs_cnt[i]), 64'(c.v_sync * ht));
        end
        last_fs[i] = n;
        en_cnt[i]  = 0;
        vs_cnt[i]  = 0;
      end
      if (en_o[i]) en_cnt[i]++;
      if (!vs_o[i]) vs_cnt[i]++;
      if (!vh_o[i]) begin
        hs_run[i]++;
      end else begin
        if (hs_run[i] > 0)
          check($sformatf("hsync_width inst%0d", i), 64'(hs_run[i]), 64'(c.h_sync));
        hs_run[i] = 0;
      end
    end
  endtask

  task automatic check_reset(input string tag);
    for (int i = 0; i < NI; i++)
      check($sformatf("%s inst%0d", tag, i),
            64'({hc_o[i], vc_o[i], vs_o[i], en_o[i], fs_o[i], vh_o[i], vv_o[i], rgb_o[i]}),
            64'({10'd0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 12'd0}));
  endtask

  task automatic release_reset();
    rst = 1'b1;
    n   = 0;
    for (int i = 0; i < NI; i++) begin
      exp_q[i].delete();
      last_fs[i] = 0;
      en_cnt[i]  = 0;
      vs_cnt[i]  = 0;
      hs_run[i]  = 0;
      push_for(i, 0);
    end
  endtask

  task automatic run_cycles(input int count);
    repeat (count) begin
      @(posedge clk);
      n++;
      #1;
      apply_stimulus();
      @(negedge clk);
      check_output();
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    n        = 0;
    for (int i = 0; i < NI; i++) pix_i[i] = 12'd0;

    add_vec(0, 655, 0, 1'b0, 1'b1, 1'b1);
    add_vec(0, 656, 0, 1'b0, 1'b1, 1'b0);
    add_vec(0, 751, 0, 1'b0, 1'b1, 1'b0);
    add_vec(0, 752, 0, 1'b0, 1'b1, 1'b1);
    add_vec(0, 159, 0, 1'b1, 1'b1, 1'b1);
    add_vec(0, 160, 0, 1'b0, 1'b1, 1'b1);
    add_vec(0, 0,   1, 1'b1, 1'b1, 1'b1);
    add_vec(0, 639, 2, 1'b0, 1'b1, 1'b1);
    add_vec(0, 799, 3, 1'b0, 1'b1, 1'b1);
    add_vec(1, 0,  0,  1'b1, 1'b1, 1'b1);
    add_vec(1, 9,  7,  1'b1, 1'b1, 1'b1);
    add_vec(1, 10, 7,  1'b0, 1'b1, 1'b1);
    add_vec(1, 0,  8,  1'b0, 1'b1, 1'b1);
    add_vec(1, 43, 0,  1'b0, 1'b1, 1'b1);
    add_vec(1, 44, 0,  1'b0, 1'b1, 1'b0);
    add_vec(1, 51, 0,  1'b0, 1'b1, 1'b0);
    add_vec(1, 52, 0,  1'b0, 1'b1, 1'b1);
    add_vec(1, 0,  31, 1'b0, 1'b1, 1'b1);
    add_vec(1, 0,  32, 1'b0, 1'b0, 1'b1);
    add_vec(1, 59, 33, 1'b0, 1'b0, 1'b1);
    add_vec(1, 0,  34, 1'b0, 1'b1, 1'b1);
    add_vec(1, 59, 37, 1'b0, 1'b1, 1'b1);
    add_vec(2, 11, 9,  1'b0, 1'b1, 1'b1);
    add_vec(2, 12, 9,  1'b1, 1'b1, 1'b1);
    add_vec(2, 21, 16, 1'b1, 1'b1, 1'b1);
    add_vec(2, 22, 16, 1'b0, 1'b1, 1'b1);
    add_vec(2, 12, 8,  1'b0, 1'b1, 1'b1);
    add_vec(2, 12, 17, 1'b0, 1'b1, 1'b1);
    add_vec(2, 0,  0,  1'b0, 1'b1, 1'b1);

    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("power_on_reset");
    release_reset();

    // Two full scaled frames plus part of a third, ending inside the scaled vsync pulse.
    run_cycles(6530);

    #2 rst = 1'b0;
    #1 check_reset("mid_frame_reset");
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    release_reset();

    run_cycles(1);
    for (int i = 0; i < NI; i++)
      check($sformatf("frame_start_after_release inst%0d", i), 64'(fs_o[i]), 64'd1);
    run_cycles(2400);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Generates 640x480@60 Hz VGA timing from the 25 MHz pixel clock and drives the frame-buffer read side. Produces the window enable and vsync consumed by the read address generator, and a display pipeline that re-aligns the frame-buffer read data with the delayed sync and blank signals. Sits between the pixel clock domain root and the VGA output pins.

Parameters:
H_VIS, 640, visible pixels per line
H_FP, 16, horizontal front porch
H_SYNC, 96, hsync pulse width
H_BP, 48, horizontal back porch
V_VIS, 480, visible lines
V_FP, 10, vertical front porch
V_SYNC, 2, vsync pulse width
V_BP, 33, vertical back porch
WIN_X, 0, first column of the frame-buffer window
WIN_Y, 0, first row of the frame-buffer window
WIN_W, 160, window width in pixels
WIN_H, 120, window height in lines
RD_LAT, 1, frame-buffer read latency in cycles (1..4)
PIX_W, 12, pixel width (RGB444)

Ports:
clk25  in  1  25 MHz pixel clock
rst  in  1  asynchronous active-low reset
enable  out  1  window-active strobe to the address generator
vsync  out  1  vsync to the address generator (active-low)
hcount  out  10  current column, aligned with enable
vcount  out  10  current line, aligned with enable
frame_start  out  1  one-cycle pulse at hcount=0, vcount=0
pixel_in  in  PIX_W  frame-buffer read data, valid RD_LAT cycles after enable
vga_hsync  out  1  hsync pin (active-low), delayed to match pixel data
vga_vsync  out  1  vsync pin (active-low), delayed to match pixel data
vga_rgb  out  PIX_W  pixel to DAC; zero outside the window and during blanking

Behaviour:
- Clock and reset: one clock, clk25. Reset is asynchronous and active-low on rst.
- Counters: h_cnt runs 0..H_TOT-1 (H_TOT=800) and wraps to 0. v_cnt increments when h_cnt wraps, runs 0..V_TOT-1 (V_TOT=525) and wraps to 0. Counters are 10 bits and unsigned.
- Stage 0 outputs are registered from the counters, so each output shows the counter state of the previous cycle:
  - hcount = h_cnt, vcount = v_cnt.
  - hsync is low for h_cnt in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC-1], i.e. 656..751.
  - vsync is low for v_cnt in [V_VIS+V_FP, V_VIS+V_FP+V_SYNC-1], i.e. 490..491, for full lines.
  - enable = 1 iff h_cnt is in [WIN_X, WIN_X+WIN_W-1] and v_cnt is in [WIN_Y, WIN_Y+WIN_H-1].
  - active = 1 iff h_cnt < H_VIS and v_cnt < V_VIS.
  - frame_start = 1 iff h_cnt == 0 and v_cnt == 0.
- Enable count: exactly WIN_W*WIN_H enable cycles per frame (19200 at defaults). This matches the address generator's terminal count. The vsync low period resets the address generator before the next window.
- Display pipeline: hsync, vsync, active and enable are delayed RD_LAT cycles through a shift register. vga_rgb = pixel_in when both delayed enable and delayed active are 1, otherwise 0. vga_rgb, vga_hsync and vga_vsync are registered after that, so total pin latency from stage 0 is RD_LAT+1.
- Reset values:
  - h_cnt = v_cnt = 0; hcount = vcount = 0.
  - enable = 0; frame_start = 0.
  - vsync = vga_vsync = vga_hsync = 1.
  - vga_rgb = 0; the delay line is cleared to the inactive levels (sync = 1, others = 0).
- Reset mid-frame: all outputs return to their reset values immediately (asynchronous). After release, timing restarts at h_cnt=0, v_cnt=0. The first frame_start occurs on the first clock edge after release.
- Window boundary: a window with WIN_X+WIN_W > H_VIS or WIN_Y+WIN_H > V_VIS is a configuration error. It is flagged by an elaboration-time assertion; gating with active guarantees no pixels are emitted during blanking.
- Simultaneous wrap: on the cycle h_cnt wraps at v_cnt = V_TOT-1, both counters go to 0 on the same edge.

Decomposition:
- Package vga_pkg holds:
  - the H_*/V_* timing defaults and derived H_TOT/V_TOT constants;
  - typedef pix_t (logic [PIX_W-1:0]);
  - typedef vga_ctrl_t, a struct of hsync, vsync, active and enable, used by the delay line.
- One sub-module: vga_delay_line, a parameterised RD_LAT-deep shift register of vga_ctrl_t with asynchronous active-low reset to the inactive values.

Test Plan:
- Reset release, run 2 frames:
  - 800 clocks per line, 525 lines per frame.
  - frame_start period 420000 cycles.
  - vsync low for exactly 1600 cycles per frame.
- Line timing: hsync falls at hcount=656, rises at hcount=752. hsync is never low for the 640 visible columns.
- Window count with defaults: 19200 enable cycles per frame, with enable high only for hcount 0..159 and vcount 0..119.
- Pipeline alignment:
  - With RD_LAT=1, drive pixel_in = {vcount[5:0], hcount[5:0]} delayed 1 cycle. vga_rgb must match that value for each window pixel, 2 cycles after its enable.
  - vga_rgb must be 0 at hcount=160..639 and during blanking.
- Reset mid-line: assert rst at h_cnt=400, v_cnt=300.
  - Outputs take their reset values immediately (vsync=1, enable=0, vga_rgb=0).
  - After release, the next frame_start follows within 1 cycle.
- Offset window WIN_X=240, WIN_Y=180: enable first rises at hcount=240, vcount=180. The last enable is at hcount=399, vcount=299. Total is still 19200.
